mont_sync_fifo: RTL and testbench

Parametrised synchronous FIFO for the RSA Montgomery datapath. It buffers exponent, modulus and operand words between the host loader and the modular-multiplication engine. Power-of-two depth and exact full/empty tracking replace the fixed-depth FIFO. It adds:
- a selectable first-word-fall-through (FWFT) read mode,
- programmable almost-full/almost-empty thresholds,
- a synchronous flush,
- sticky overflow/underflow error flags.

---
 rtl/mont_sync_fifo_if.sv | 32 +++
 rtl/mont_sync_fifo.sv | 117 +++++++++++
 tb/tb_mont_sync_fifo.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mont_sync_fifo_if.sv
// Handshake and status bundle between the host loader, the FIFO and the
// Montgomery multiplication engine.
interface mont_sync_fifo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/mont_sync_fifo.sv
// Power-of-two synchronous FIFO feeding the Montgomery engine: registered or
// first-word-fall-through read, almost thresholds, flush and sticky errors.
module mont_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int FWFT   = 0,
  parameter int AF_LVL = (1 << ADDR_W) - 4,
  parameter int AE_LVL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mont_sync_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_CNT   = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0]   AE_CNT   = (ADDR_W+1)'(AE_LVL);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              overflow_r;
  logic              underflow_r;
  logic              full_s;
  logic              empty_s;
  logic              wr_acc_s;
  logic              rd_acc_s;

  // Status depends only on the registered count, so full never admits a
  // same-cycle write even when a read is also accepted.
  assign full_s   = (count_r == CNT_FULL);
  assign empty_s  = (count_r == {(ADDR_W+1){1'b0}});
  assign wr_acc_s = bus.wr_en & ~full_s  & ~bus.flush;
  assign rd_acc_s = bus.rd_en & ~empty_s & ~bus.flush;

  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_r >= AF_CNT);
  assign bus.almost_empty = (count_r <= AE_CNT);
  assign bus.count        = count_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;

  // Storage array: written on accepted writes, never cleared.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      count_r     <= {(ADDR_W+1){1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      count_r     <= {(ADDR_W+1){1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (bus.wr_en && full_s) begin
        overflow_r <= 1'b1;
      end
      if (bus.rd_en && empty_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rd_data  = mem_r[rd_ptr_r];
      assign bus.rd_valid = ~empty_s;
    end else begin : g_reg
      logic [DATA_W-1:0] rd_data_r;
      logic              rd_valid_r;

      // Registered read port; rd_valid pulses for one cycle per accepted read.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_r  <= {DATA_W{1'b0}};
          rd_valid_r <= 1'b0;
        end else if (bus.flush) begin
          rd_data_r  <= {DATA_W{1'b0}};
          rd_valid_r <= 1'b0;
        end else begin
          rd_valid_r <= rd_acc_s;
          if (rd_acc_s) begin
            rd_data_r <= mem_r[rd_ptr_r];
          end
        end
      end

      assign bus.rd_data  = rd_data_r;
      assign bus.rd_valid = rd_valid_r;
    end
  endgenerate
endmodule

// File: tb/tb_mont_sync_fifo.sv
// Scoreboard bench for mont_sync_fifo: registered-read instance checked every
// cycle against a queue model, plus a first-word-fall-through instance.
module tb_mont_sync_fifo;
  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int DEP = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [DW-1:0] exp_q[$];
  int            m_cnt = 0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  mont_sync_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  mont_sync_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

  mont_sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .FWFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  mont_sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  always #5 clk = ~clk;

  // One clock of stimulus on the registered-read instance, then compare all
  // outputs against the queue model.
  task automatic step(input logic wr, input logic [DW-1:0] wd, input logic rd, input logic fl);
    logic wa, ra;
    logic [DW-1:0] e;
    if0.wr_en = wr; if0.wr_data = wd; if0.rd_en = rd; if0.flush = fl;
    wa = wr && (m_cnt != DEP) && !fl;
    ra = rd && (m_cnt != 0) && !fl;
    @(posedge clk); #1;
    if0.wr_en = 1'b0; if0.rd_en = 1'b0; if0.flush = 1'b0;
    if (fl) begin
      exp_q.delete(); m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (wr && m_cnt == DEP) m_ovf = 1'b1;
      if (rd && m_cnt == 0) m_unf = 1'b1;
      if (ra) begin
        e = exp_q.pop_front();
        m_cnt--;
        n_vec++;
        if (if0.rd_data !== e) begin
          n_err++; $display("FAIL rd_data: got %0h expected %0h", if0.rd_data, e);
        end
      end
      if (wa) begin
        exp_q.push_back(wd);
        m_cnt++;
      end
    end
    n_vec++;
    if (if0.rd_valid !== ra) begin
      n_err++; $display("FAIL rd_valid: got %0b expected %0b", if0.rd_valid, ra);
    end
    n_vec++;
    if (if0.count !== (AW+1)'(m_cnt)) begin
      n_err++; $display("FAIL count: got %0d expected %0d", if0.count, m_cnt);
    end
    n_vec++;
    if (if0.full !== (m_cnt == DEP) || if0.empty !== (m_cnt == 0)) begin
      n_err++; $display("FAIL full_empty: got %0b%0b expected %0b%0b", if0.full, if0.empty, m_cnt == DEP, m_cnt == 0);
    end
    n_vec++;
    if (if0.almost_full !== (m_cnt >= DEP - 4) || if0.almost_empty !== (m_cnt <= 4)) begin
      n_err++; $display("FAIL almost: got %0b%0b expected %0b%0b", if0.almost_full, if0.almost_empty, m_cnt >= DEP - 4, m_cnt <= 4);
    end
    n_vec++;
    if (if0.overflow !== m_ovf || if0.underflow !== m_unf) begin
      n_err++; $display("FAIL err_flags: got %0b%0b expected %0b%0b", if0.overflow, if0.underflow, m_ovf, m_unf);
    end
  endtask

  task automatic test_reset();
    if0.flush = 1'b0; if0.wr_en = 1'b0; if0.rd_en = 1'b0; if0.wr_data = '0;
    if1.flush = 1'b0; if1.wr_en = 1'b0; if1.rd_en = 1'b0; if1.wr_data = '0;
    #3 rst_n = 1'b0;
    #20;
    n_vec++;
    if (if0.count !== 7'd0 || if0.empty !== 1'b1 || if0.full !== 1'b0) begin
      n_err++; $display("FAIL reset_count: got cnt=%0d e=%0b f=%0b expected 0 1 0", if0.count, if0.empty, if0.full);
    end
    n_vec++;
    if (if0.almost_empty !== 1'b1 || if0.almost_full !== 1'b0) begin
      n_err++; $display("FAIL reset_almost: got ae=%0b af=%0b expected 1 0", if0.almost_empty, if0.almost_full);
    end
    n_vec++;
    if (if0.rd_data !== 32'd0 || if0.rd_valid !== 1'b0 || if0.overflow !== 1'b0 || if0.underflow !== 1'b0) begin
      n_err++; $display("FAIL reset_read: got d=%0h v=%0b o=%0b u=%0b expected 0 0 0 0", if0.rd_data, if0.rd_valid, if0.overflow, if0.underflow);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEP; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    n_vec++;
    if (if0.full !== 1'b1 || if0.count !== 7'd64) begin
      n_err++; $display("FAIL fill_full: got f=%0b cnt=%0d expected 1 64", if0.full, if0.count);
    end
    for (int i = 1; i <= DEP; i++) step(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    if (if0.empty !== 1'b1) begin
      n_err++; $display("FAIL drain_empty: got %0b expected 1", if0.empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEP; i++) step(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_0001, 1'b0, 1'b0);
    n_vec++;
    if (if0.count !== 7'd64 || if0.overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_wr: got cnt=%0d o=%0b expected 64 1", if0.count, if0.overflow);
    end
    step(1'b1, 32'hDEAD_0002, 1'b1, 1'b0);
    n_vec++;
    if (if0.count !== 7'd63) begin
      n_err++; $display("FAIL ovf_wr_rd: got cnt=%0d expected 63", if0.count);
    end
    for (int i = 0; i < DEP - 1; i++) step(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    if (if0.overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_sticky: got %0b expected 1", if0.overflow);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_00A5, 1'b1, 1'b0);
    n_vec++;
    if (if0.underflow !== 1'b1 || if0.count !== 7'd1) begin
      n_err++; $display("FAIL unf: got u=%0b cnt=%0d expected 1 1", if0.underflow, if0.count);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    if (if0.rd_data !== 32'h0000_00A5) begin
      n_err++; $display("FAIL unf_data: got %0h expected a5", if0.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h2000 + i), 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) step(1'b1, DW'(32'h3000 + i), 1'b1, 1'b0);
    n_vec++;
    if (if0.count !== 7'd3) begin
      n_err++; $display("FAIL b2b_count: got %0d expected 3", if0.count);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, DW'(32'h4000 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_7777, 1'b1, 1'b1);
    n_vec++;
    if (if0.count !== 7'd0 || if0.empty !== 1'b1 || if0.overflow !== 1'b0 || if0.underflow !== 1'b0 || if0.rd_data !== 32'd0) begin
      n_err++; $display("FAIL flush: got cnt=%0d e=%0b o=%0b u=%0b d=%0h expected 0 1 0 0 0",
                        if0.count, if0.empty, if0.overflow, if0.underflow, if0.rd_data);
    end
    step(1'b1, 32'h0000_5A5A, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_fwft();
    if1.wr_en = 1'b1; if1.wr_data = 32'h11;
    @(posedge clk); #1 if1.wr_en = 1'b0;
    n_vec++;
    if (if1.rd_data !== 32'h11 || if1.rd_valid !== 1'b1) begin
      n_err++; $display("FAIL fwft_head: got d=%0h v=%0b expected 11 1", if1.rd_data, if1.rd_valid);
    end
    if1.wr_en = 1'b1; if1.wr_data = 32'h22;
    @(posedge clk); #1 if1.wr_en = 1'b0;
    if1.rd_en = 1'b1;
    @(posedge clk); #1 if1.rd_en = 1'b0;
    n_vec++;
    if (if1.rd_data !== 32'h22 || if1.rd_valid !== 1'b1) begin
      n_err++; $display("FAIL fwft_next: got d=%0h v=%0b expected 22 1", if1.rd_data, if1.rd_valid);
    end
    if1.rd_en = 1'b1;
    @(posedge clk); #1 if1.rd_en = 1'b0;
    n_vec++;
    if (if1.rd_valid !== 1'b0 || if1.empty !== 1'b1) begin
      n_err++; $display("FAIL fwft_pop: got v=%0b e=%0b expected 0 1", if1.rd_valid, if1.empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, DW'(32'h5000 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    if0.wr_en = 1'b1; if0.wr_data = 32'h6000;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (if0.count !== 7'd0 || if0.empty !== 1'b1 || if0.rd_valid !== 1'b0 || if0.rd_data !== 32'd0) begin
      n_err++; $display("FAIL reset_mid: got cnt=%0d e=%0b v=%0b d=%0h expected 0 1 0 0",
                        if0.count, if0.empty, if0.rd_valid, if0.rd_data);
    end
    if0.wr_en = 1'b0;
    exp_q.delete(); m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    step(1'b1, 32'h0000_6001, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_flush();
    test_fwft();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
